// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO between instruction fetch and decode.
// Fetch pushes one {inst, pc} per cycle; decode pops the head entry.
// A squash drops every buffered entry in a single cycle. When empty,
// the head presents a NOP with valid low so decode emits a bubble.
module inst_buffer #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   squash,
   input  logic                   if_valid,
   input  logic [31:0]            if_inst,
   input  logic [XLEN-1:0]        if_pc,
   output logic                   if_ready,
   input  logic                   id_ready,
   output logic                   id_valid,
   output logic [31:0]            id_inst,
   output logic [XLEN-1:0]        id_pc,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 32 + XLEN;

   localparam logic [31:0]   NOP_INST = 32'h0000_0013;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Entry storage: {inst, pc}. Contents are meaningless for unoccupied slots.
   logic [EW-1:0] mem_q [DEPTH];

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          push;
   logic          pop;
   logic [EW-1:0] head_entry;

   // Handshake status is derived from the registered occupancy only, so a
   // pop in the same cycle never opens room for a push when full.
   always_comb begin
      if_ready   = (count_q != FULL_CNT);
      id_valid   = (count_q != '0);
      head_entry = mem_q[head_q];
      id_inst    = NOP_INST;
      id_pc      = '0;
      if (id_valid) begin
         id_inst = head_entry[EW-1:XLEN];
         id_pc   = head_entry[XLEN-1:0];
      end
      count = count_q;
   end

   // Squash dominates: a flush cycle performs neither a push nor a pop.
   always_comb begin
      push = if_valid & if_ready & ~squash;
      pop  = id_valid & id_ready & ~squash;
   end

   // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (squash) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            tail_d = tail_q + AW'(1);
         end
         if (pop) begin
            head_d = head_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state: asynchronously cleared, updated every rising edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry write at the tail; data storage needs no reset.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[tail_q] <= {if_inst, if_pc};
      end
   end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer. A queue scoreboard records every
// instruction that should be accepted and is compared at each pop.
module tb_inst_buffer;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              squash = 1'b0;
   logic              if_valid = 1'b0;
   logic [31:0]       if_inst = '0;
   logic [XLEN-1:0]   if_pc = '0;
   logic              if_ready;
   logic              id_ready = 1'b0;
   logic              id_valid;
   logic [31:0]       id_inst;
   logic [XLEN-1:0]   id_pc;
   logic [2:0]        count;

   int total = 0;
   int bad   = 0;

   logic [63:0] sb [$];

   inst_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock    (clock),
      .reset    (reset),
      .squash   (squash),
      .if_valid (if_valid),
      .if_inst  (if_inst),
      .if_pc    (if_pc),
      .if_ready (if_ready),
      .id_ready (id_ready),
      .id_valid (id_valid),
      .id_inst  (id_inst),
      .id_pc    (id_pc),
      .count    (count)
   );

   always #5 clock = ~clock;

   // One clock cycle of stimulus. Inputs are applied 1 time unit after an
   // edge; the scoreboard pops (and compares) the head when a pop is due,
   // and records the pushed entry when the buffer model has room.
   task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic sq);
      logic [63:0] exp;
      bit          room;
      if_valid = v;
      if_inst  = inst;
      if_pc    = pc;
      id_ready = rdy;
      squash   = sq;
      room     = (sb.size() < DEPTH);
      if (sq) begin
         sb.delete();
      end else begin
         if (rdy && sb.size() > 0) begin
            exp = sb.pop_front();
            total++;
            if ({id_inst, id_pc} !== exp) begin
               bad++;
               $display("FAIL pop_data got=%h_%h want=%h_%h", id_inst, id_pc, exp[63:32], exp[31:0]);
            end
         end
         if (v && room) sb.push_back({inst, pc});
      end
      @(posedge clock);
      #1;
      if_valid = 1'b0;
      id_ready = 1'b0;
      squash   = 1'b0;
      total++;
      if (count !== 3'(sb.size()) || id_valid !== (sb.size() != 0)) begin
         bad++;
         $display("FAIL occupancy count=%0d valid=%b want count=%0d", count, id_valid, sb.size());
      end
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) begin
         if (sb.size() > 0) step(1'b0, '0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset();
      // During initial reset
      #2;
      total++;
      if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== '0 || count !== '0 || if_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_init valid=%b inst=%h pc=%h count=%0d rdy=%b", id_valid, id_inst, id_pc, count, if_ready);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      // Mid-run reset with three entries held
      for (int i = 0; i < 3; i++) step(1'b1, 32'hA000_0000 + i, 32'h100 + 4 * i, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== '0 || count !== '0 || if_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_midrun valid=%b inst=%h pc=%h count=%0d rdy=%b", id_valid, id_inst, id_pc, count, if_ready);
      end
      sb.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_single();
      step(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
      total++;
      if (id_valid !== 1'b1 || id_inst !== 32'h0050_0093 || id_pc !== 32'h0 || count !== 3'd1) begin
         bad++;
         $display("FAIL single_pass valid=%b inst=%h pc=%h count=%0d", id_valid, id_inst, id_pc, count);
      end
      drain();
   endtask

   task automatic test_fill_full();
      for (int i = 0; i < 4; i++) step(1'b1, 32'hB000_0000 + i, 32'(4 * i), 1'b0, 1'b0);
      total++;
      if (count !== 3'd4 || if_ready !== 1'b0) begin
         bad++;
         $display("FAIL full count=%0d if_ready=%b want 4/0", count, if_ready);
      end
      step(1'b1, 32'hB000_0004, 32'h10, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (id_pc !== 32'(4 * i)) begin
            bad++;
            $display("FAIL full_order pc=%h want=%h", id_pc, 32'(4 * i));
         end
         step(1'b0, '0, '0, 1'b1, 1'b0);
      end
      total++;
      if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== '0) begin
         bad++;
         $display("FAIL full_dropped valid=%b inst=%h pc=%h", id_valid, id_inst, id_pc);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] prev;
      step(1'b1, 32'hC000_0000, 32'h200, 1'b0, 1'b0);
      step(1'b1, 32'hC000_0001, 32'h204, 1'b0, 1'b0);
      prev = id_pc;
      for (int i = 2; i < 12; i++) begin
         step(1'b1, 32'hC000_0000 + i, 32'h200 + 4 * i, 1'b1, 1'b0);
         total++;
         if (count !== 3'd2 || id_pc !== prev + 32'd4) begin
            bad++;
            $display("FAIL back_to_back count=%0d pc=%h want 2/%h", count, id_pc, prev + 32'd4);
         end
         prev = id_pc;
      end
      drain();
   endtask

   task automatic test_squash();
      for (int i = 0; i < 3; i++) step(1'b1, 32'hD000_0000 + i, 32'h300 + 4 * i, 1'b0, 1'b0);
      step(1'b1, 32'hDEAD_BEEF, 32'h3FC, 1'b1, 1'b1);
      total++;
      if (count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1 || id_inst !== NOP) begin
         bad++;
         $display("FAIL squash count=%0d valid=%b rdy=%b inst=%h", count, id_valid, if_ready, id_inst);
      end
      step(1'b1, 32'hD100_0000, 32'h400, 1'b0, 1'b0);
      total++;
      if (id_inst !== 32'hD100_0000 || id_pc !== 32'h400) begin
         bad++;
         $display("FAIL squash_refill inst=%h pc=%h want d1000000/400", id_inst, id_pc);
      end
      drain();
   endtask

   task automatic test_boundary();
      for (int i = 0; i < 3; i++) step(1'b1, 32'hE000_0000 + i, 32'h500 + 4 * i, 1'b0, 1'b0);
      step(1'b1, 32'hE000_0003, 32'h50C, 1'b1, 1'b0);
      total++;
      if (count !== 3'd3 || if_ready !== 1'b1) begin
         bad++;
         $display("FAIL boundary3 count=%0d if_ready=%b want 3/1", count, if_ready);
      end
      step(1'b1, 32'hE000_0004, 32'h510, 1'b0, 1'b0);
      step(1'b1, 32'hE000_0005, 32'h514, 1'b1, 1'b0);
      total++;
      if (count !== 3'd3 || if_ready !== 1'b1) begin
         bad++;
         $display("FAIL boundary4 count=%0d if_ready=%b want 3/1", count, if_ready);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_full();
      test_back_to_back();
      test_squash();
      test_boundary();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
